// File: rtl/nic_fifo.sv
// nic_fifo: processor-to-router network interface with two circular FIFOs.
// The out FIFO is filled by processor writes and drained toward the router
// when the head packet's virtual-channel tag (bit DW-1) matches the router
// polarity. The in FIFO is filled by the router and drained by processor
// reads. Processor reads are registered and appear on d_out one cycle later.
module nic_fifo #(
    parameter int DW    = 64,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [1:0]    addr,
    input  logic [DW-1:0] d_in,
    input  logic          nicEN,
    input  logic          nicWrEn,
    output logic [DW-1:0] d_out,
    output logic          net_so,
    input  logic          net_ro,
    output logic [DW-1:0] net_do,
    input  logic          net_polarity,
    input  logic          net_si,
    output logic          net_ri,
    input  logic [DW-1:0] net_di
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    localparam logic [1:0] ADDR_IN_DATA    = 2'b00;
    localparam logic [1:0] ADDR_IN_STATUS  = 2'b01;
    localparam logic [1:0] ADDR_OUT_DATA   = 2'b10;
    localparam logic [1:0] ADDR_OUT_STATUS = 2'b11;

    // Storage arrays (contents are not reset; pointers/counts define validity)
    logic [DW-1:0] out_mem [DEPTH];
    logic [DW-1:0] in_mem  [DEPTH];

    // Out FIFO state
    logic [AW-1:0] out_wr_ptr_reg, out_rd_ptr_reg;
    logic [CW-1:0] out_count_reg, out_count_next;
    logic          out_ovf_reg, out_ovf_next;

    // In FIFO state
    logic [AW-1:0] in_wr_ptr_reg, in_rd_ptr_reg;
    logic [CW-1:0] in_count_reg, in_count_next;
    logic          net_ri_reg, net_ri_next;

    // Registered processor read data
    logic [DW-1:0] d_out_reg, d_out_next;

    // Decoded access strobes
    logic          wr_access, rd_access;
    logic          out_push_req, out_push, out_pop, out_ovf_evt, out_full;
    logic          in_push, in_pop, in_nonempty;
    logic [DW-1:0] out_head, in_head;
    logic          send_ok;
    logic [DW-1:0] in_status, out_status;

    assign wr_access    = nicEN & nicWrEn;
    assign rd_access    = nicEN & ~nicWrEn;

    assign out_full     = (out_count_reg == FULL_CNT);
    assign out_push_req = wr_access & (addr == ADDR_OUT_DATA);
    // Push is gated by the count at the start of the cycle, so a push into a
    // full FIFO is dropped even when a send pops the head in the same cycle.
    assign out_push     = out_push_req & ~out_full;
    assign out_ovf_evt  = out_push_req & out_full;

    assign out_head     = out_mem[out_rd_ptr_reg];
    assign send_ok      = net_ro & (out_count_reg != '0) & (net_polarity == out_head[DW-1]);
    assign out_pop      = send_ok;

    assign net_so       = send_ok;
    assign net_do       = send_ok ? out_head : '0;

    assign in_nonempty  = (in_count_reg != '0);
    assign in_head      = in_mem[in_rd_ptr_reg];
    assign in_push      = net_ri_reg & net_si;
    assign in_pop       = rd_access & (addr == ADDR_IN_DATA) & in_nonempty;

    assign d_out        = d_out_reg;
    assign net_ri       = net_ri_reg;

    // Status words: flags in the top bits, occupancy count in the low CW bits
    always_comb begin
        in_status             = '0;
        in_status[DW-1]       = in_nonempty;
        in_status[CW-1:0]     = in_count_reg;
        out_status            = '0;
        out_status[DW-1]      = out_full;
        out_status[DW-2]      = out_ovf_reg;
        out_status[CW-1:0]    = out_count_reg;
    end

    // Out FIFO occupancy and sticky overflow flag for the coming edge
    always_comb begin
        out_count_next = out_count_reg;
        case ({out_push, out_pop})
            2'b10:   out_count_next = out_count_reg + CW'(1);
            2'b01:   out_count_next = out_count_reg - CW'(1);
            default: out_count_next = out_count_reg;
        endcase
        out_ovf_next = out_ovf_reg;
        if (out_ovf_evt) begin
            out_ovf_next = 1'b1;
        end else if (rd_access && (addr == ADDR_OUT_STATUS)) begin
            out_ovf_next = 1'b0;
        end
    end

    // In FIFO occupancy and receive-ready for the coming edge
    always_comb begin
        in_count_next = in_count_reg;
        case ({in_push, in_pop})
            2'b10:   in_count_next = in_count_reg + CW'(1);
            2'b01:   in_count_next = in_count_reg - CW'(1);
            default: in_count_next = in_count_reg;
        endcase
        net_ri_next = (in_count_next < FULL_CNT);
    end

    // Processor read mux; writes hold d_out, idle cycles clear it
    always_comb begin
        d_out_next = d_out_reg;
        if (!nicEN) begin
            d_out_next = '0;
        end else if (!nicWrEn) begin
            case (addr)
                ADDR_IN_DATA:    d_out_next = in_nonempty ? in_head : '0;
                ADDR_IN_STATUS:  d_out_next = in_status;
                ADDR_OUT_DATA:   d_out_next = '0;
                ADDR_OUT_STATUS: d_out_next = out_status;
                default:         d_out_next = '0;
            endcase
        end
    end

    // Out FIFO pointer, count and overflow registers
    always_ff @(posedge clk) begin
        if (rst) begin
            out_wr_ptr_reg <= '0;
            out_rd_ptr_reg <= '0;
            out_count_reg  <= '0;
            out_ovf_reg    <= 1'b0;
        end else begin
            if (out_push) out_wr_ptr_reg <= out_wr_ptr_reg + AW'(1);
            if (out_pop)  out_rd_ptr_reg <= out_rd_ptr_reg + AW'(1);
            out_count_reg <= out_count_next;
            out_ovf_reg   <= out_ovf_next;
        end
    end

    // In FIFO pointer, count and receive-ready registers
    always_ff @(posedge clk) begin
        if (rst) begin
            in_wr_ptr_reg <= '0;
            in_rd_ptr_reg <= '0;
            in_count_reg  <= '0;
            net_ri_reg    <= 1'b1;
        end else begin
            if (in_push) in_wr_ptr_reg <= in_wr_ptr_reg + AW'(1);
            if (in_pop)  in_rd_ptr_reg <= in_rd_ptr_reg + AW'(1);
            in_count_reg <= in_count_next;
            net_ri_reg   <= net_ri_next;
        end
    end

    // Registered processor read data
    always_ff @(posedge clk) begin
        if (rst) begin
            d_out_reg <= '0;
        end else begin
            d_out_reg <= d_out_next;
        end
    end

    // Out FIFO storage write port (no reset on the array)
    always_ff @(posedge clk) begin
        if (!rst && out_push) begin
            out_mem[out_wr_ptr_reg] <= d_in;
        end
    end

    // In FIFO storage write port (no reset on the array)
    always_ff @(posedge clk) begin
        if (!rst && in_push) begin
            in_mem[in_wr_ptr_reg] <= net_di;
        end
    end

endmodule
